// File: rtl/fsm1_sched_pkg.sv
// rtl/fsm1_sched_pkg.sv - shared types and defaults for the round-robin read scheduler
package fsm1_sched_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DLY   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4,
    XXX   = 'x
  } sched_e;

  // A single client still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm1_rr_sched_arbiter.sv
// rtl/fsm1_rr_sched_arbiter.sv - combinational round-robin pick: first set req at or after ptr
module rr_arbiter
  import fsm1_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win_id,
  output logic            any
);

  logic [NREQ-1:0] w_rot;
  logic [IDW:0]    w_sum;

  // Rotating by ptr turns "first at or after ptr" into "lowest set bit".
  always_comb begin
    w_rot  = NREQ'({req, req} >> ptr);
    w_sum  = '0;
    win_id = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_rot[k] && !any) begin
        any   = 1'b1;
        w_sum = {1'b0, ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end
        win_id = w_sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fsm1_rr_sched.sv
// rtl/fsm1_rr_sched.sv - round-robin scheduler sharing one rd/ds read engine among NREQ clients
module fsm1_rr_sched
  import fsm1_sched_pkg::*;
#(
  parameter  int NREQ    = NREQ_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IDW     = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            ws,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            rd,
  output logic            ds,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic            busy
);

  localparam int             WCW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WLAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

  sched_e          r_state;
  sched_e          w_next;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_ptr;
  logic [WCW-1:0]  r_wcnt;
  logic [IDW-1:0]  w_win_id;
  logic            w_any;
  logic [IDW-1:0]  w_owner_nxt;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_timeout;

  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic            r_rd;
  logic            r_ds;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic            r_busy;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (r_ptr),
    .win_id (w_win_id),
    .any    (w_any)
  );

  // Outputs decode from next state, so the owner must be the one being latched this edge.
  assign w_owner_nxt = (r_state == IDLE) ? w_win_id : r_owner;
  assign w_owner_oh  = NREQ'(1) << w_owner_nxt;
  assign w_ptr_nxt   = (w_owner_nxt == IDW'(NREQ - 1)) ? '0 : w_owner_nxt + 1'b1;
  assign w_timeout   = (TIMEOUT != 0) && (r_wcnt == WLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        w_next = w_any ? READ : IDLE;
      READ:        w_next = DLY;
      DLY: begin
        if (!ws)            w_next = DONE;
        else if (w_timeout) w_next = ABORT;
        else                w_next = READ;
      end
      DONE, ABORT: w_next = IDLE;
      default:     w_next = XXX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= '0;
      r_ptr    <= '0;
      r_wcnt   <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_rd     <= 1'b0;
      r_ds     <= 1'b0;
      r_done   <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_next == READ) begin
        r_owner <= w_win_id;
        r_wcnt  <= '0;
      end else if (r_state == DLY && w_next == READ) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_next == DONE || w_next == ABORT) begin
        r_ptr <= w_ptr_nxt;
      end

      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_rd     <= 1'b0;
      r_ds     <= 1'b0;
      r_done   <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
      case (w_next)
        IDLE: ;
        READ, DLY: begin
          r_gnt    <= w_owner_oh;
          r_gnt_id <= w_owner_nxt;
          r_rd     <= 1'b1;
          r_busy   <= 1'b1;
        end
        DONE: begin
          r_gnt    <= w_owner_oh;
          r_gnt_id <= w_owner_nxt;
          r_ds     <= 1'b1;
          r_done   <= w_owner_oh;
          r_busy   <= 1'b1;
        end
        ABORT: begin
          r_gnt    <= w_owner_oh;
          r_gnt_id <= w_owner_nxt;
          r_err    <= w_owner_oh;
          r_busy   <= 1'b1;
        end
        default: begin
          r_gnt    <= 'x;
          r_gnt_id <= 'x;
          r_rd     <= 1'bx;
          r_ds     <= 1'bx;
          r_done   <= 'x;
          r_err    <= 'x;
          r_busy   <= 1'bx;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign rd     = r_rd;
  assign ds     = r_ds;
  assign done   = r_done;
  assign err    = r_err;
  assign busy   = r_busy;

endmodule

// File: tb/tb_fsm1_rr_sched.sv
// tb/tb_fsm1_rr_sched.sv - randomized and directed checks of fsm1_rr_sched against a transaction-level model
module tb_fsm1_rr_sched;

  localparam int N  = 4;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         ws;
  logic [N-1:0] gnt, done, err;
  logic [1:0]   gnt_id;
  logic         rd, ds, busy;

  always #5 clk = ~clk;

  fsm1_rr_sched #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ws(ws),
    .gnt(gnt), .gnt_id(gnt_id), .rd(rd), .ds(ds),
    .done(done), .err(err), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: phase 0 idle, 1 read issued, 2 waiting, 3 completed, 4 aborted.
  int m_phase, m_owner, m_ptr, m_wc;

  int           obs_rd, obs_ds;
  logic [N-1:0] obs_done, obs_err;
  int           grants[$];
  logic         prev_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_wc = 0;
    prev_busy = 1'b0;
  endtask

  task automatic clear_obs();
    obs_rd = 0; obs_ds = 0; obs_done = '0; obs_err = '0;
    grants.delete();
  endtask

  task automatic model_edge();
    case (m_phase)
      0: if (req != '0) begin
        m_owner = rr_pick(req, m_ptr);
        m_phase = 1;
        m_wc    = 0;
      end
      1: m_phase = 2;
      2: if (!ws) begin
        m_phase = 3;
        m_ptr   = (m_owner + 1) % N;
      end else if (m_wc == TO - 1) begin
        m_phase = 4;
        m_ptr   = (m_owner + 1) % N;
      end else begin
        m_wc++;
        m_phase = 1;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    logic [N-1:0] oh;
    oh = (m_phase != 0) ? (N'(1) << m_owner) : '0;
    chk("rd",     32'(rd),     32'(m_phase == 1 || m_phase == 2));
    chk("ds",     32'(ds),     32'(m_phase == 3));
    chk("busy",   32'(busy),   32'(m_phase != 0));
    chk("gnt",    32'(gnt),    32'(oh));
    chk("gnt_id", 32'(gnt_id), (m_phase != 0) ? 32'(m_owner) : 32'd0);
    chk("done",   32'(done),   (m_phase == 3) ? 32'(oh) : 32'd0);
    chk("err",    32'(err),    (m_phase == 4) ? 32'(oh) : 32'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    obs_rd   += int'(rd);
    obs_ds   += int'(ds);
    obs_done |= done;
    obs_err  |= err;
    if (busy === 1'b1 && prev_busy !== 1'b1) grants.push_back(int'(gnt_id));
    prev_busy = busy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ws = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(gnt),    32'd0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    chk({tag, "_rd"},     32'(rd),     32'd0);
    chk({tag, "_ds"},     32'(ds),     32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_err"},    32'(err),    32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  initial begin
    int visits;
    int guard;

    rst_n = 1'b0; req = '0; ws = 1'b0;
    model_reset();
    clear_obs();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, no wait states.
    do_reset();
    req = 4'b0010;
    step();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_gnt_id", 32'(gnt_id), 32'd1);
    chk("t1_rd_c1", 32'(rd), 32'd1);
    req = '0;
    step();
    chk("t1_rd_c2", 32'(rd), 32'd1);
    step();
    chk("t1_ds", 32'(ds), 32'd1);
    chk("t1_done", 32'(done), 32'h2);
    chk("t1_rd_c3", 32'(rd), 32'd0);
    step();
    chk("t1_idle", 32'(busy), 32'd0);

    // Three wait-state DLY visits, then completion.
    do_reset();
    req = 4'b0001;
    visits = 0;
    guard = 0;
    step();
    req = '0;
    while (m_phase != 0 && guard < 40) begin
      ws = (m_phase == 2 && visits < 3);
      if (ws) visits++;
      step();
      guard++;
    end
    chk("t2_guard", 32'(guard < 40), 32'd1);
    chk("t2_rd_cycles", 32'(obs_rd), 32'd8);
    chk("t2_ds_count", 32'(obs_ds), 32'd1);
    chk("t2_err", 32'(obs_err), 32'd0);
    chk("t2_done", 32'(obs_done), 32'h1);
    ws = 1'b0;

    // Fairness with all clients requesting.
    do_reset();
    req = 4'b1111;
    guard = 0;
    while (grants.size() < 8 && guard < 100) begin
      step();
      guard++;
    end
    chk("t3_grant_count", 32'(grants.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      chk($sformatf("t3_order%0d", i), 32'(grants[i]), 32'(i % 4));
    end
    req = '0;
    repeat (4) step();

    // Timeout abort, then the next client gets its turn.
    do_reset();
    req = 4'b0011;
    ws = 1'b1;
    guard = 0;
    while (obs_err == '0 && guard < 40) begin
      step();
      guard++;
    end
    chk("t4_err", 32'(obs_err), 32'h1);
    chk("t4_rd_cycles", 32'(obs_rd), 32'd8);
    chk("t4_no_ds", 32'(obs_ds), 32'd0);
    step();
    chk("t4_idle", 32'(busy), 32'd0);
    step();
    chk("t4_next_gnt", 32'(gnt), 32'h2);
    req = '0;
    ws = 1'b0;
    repeat (4) step();

    // Requester drops req after grant; transaction still completes.
    do_reset();
    req = 4'b0100;
    step();
    chk("t5_gnt", 32'(gnt), 32'h4);
    req = '0;
    step();
    step();
    chk("t5_done", 32'(done), 32'h4);
    step();
    req = 4'b1111;
    step();
    chk("t5_next_id", 32'(gnt_id), 32'd3);
    req = '0;
    repeat (6) step();

    // Asynchronous reset in the middle of a wait state.
    do_reset();
    req = 4'b0010;
    step();
    req = '0;
    repeat (3) step();
    req = 4'b0100;
    ws = 1'b1;
    step();
    req = '0;
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    model_reset();
    @(negedge clk);
    chk_all_zero("t6_held");
    rst_n = 1'b1;
    ws = 1'b0;
    req = 4'b1111;
    step();
    chk("t6_gnt_id", 32'(gnt_id), 32'd0);
    chk("t6_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (4) step();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      ws = ($urandom_range(0, 9) < 4);
      if ((c / 200) % 2 == 1 && $urandom_range(0, 4) != 0) ws = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
